// File: rtl/axi4_arb_pkg.sv
// Shared types for the AXI4 read arbiter: FSM state encoding and AXI burst-length width.
package axi4_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
  localparam int AXI_LEN_W = 8;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request searching upward from i_last+1, wrapping.
// Kept free of AXI specifics so the write-side arbiter can reuse it.
module rr_picker #(
  parameter int NM = 2,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [IW-1:0] i_last,
  output logic [NM-1:0] o_gnt_oh,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_valid
);
  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_valid   = 1'b0;
    w_idx     = '0;
    // i_last itself is visited last, so the master just served has lowest priority
    for (int k = 1; k <= NM; k++) begin
      w_idx = IW'((int'(i_last) + k) % NM);
      if (!o_valid && i_req[w_idx]) begin
        o_valid         = 1'b1;
        o_gnt_idx       = w_idx;
        o_gnt_oh[w_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR/R subset) among NM masters, one burst in flight.
// Optional AXI_RD_ARB_LEN_CHECK_EN adds a sticky len_err output from an R beat counter.
module axi4_rd_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int A_WIDTH = 26,
  parameter int D_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NM-1:0]          m_arvalid,
  output logic [NM-1:0]          m_arready,
  input  logic [NM*A_WIDTH-1:0]  m_araddr,
  input  logic [NM*8-1:0]        m_arlen,
  output logic [NM-1:0]          m_rvalid,
  input  logic [NM-1:0]          m_rready,
  output logic                   m_rlast,
  output logic [D_WIDTH-1:0]     m_rdata,
  output logic                   s_arvalid,
  input  logic                   s_arready,
  output logic [A_WIDTH-1:0]     s_araddr,
  output logic [7:0]             s_arlen,
  input  logic                   s_rvalid,
  output logic                   s_rready,
  input  logic                   s_rlast,
  input  logic [D_WIDTH-1:0]     s_rdata
`ifdef AXI_RD_ARB_LEN_CHECK_EN
  ,
  output logic                   len_err
`endif
);
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  arb_state_e             r_state;
  logic [IW-1:0]          r_grant;
  logic [IW-1:0]          r_last_grant;
  logic [NM-1:0]          r_gnt_oh;
  logic                   r_arvalid;
  logic [A_WIDTH-1:0]     r_araddr;
  logic [AXI_LEN_W-1:0]   r_arlen;

  logic [A_WIDTH-1:0]     w_addr [NM];
  logic [AXI_LEN_W-1:0]   w_len  [NM];
  logic [NM-1:0]          w_req_oh;
  logic [IW-1:0]          w_req_idx;
  logic                   w_req_vld;
  logic                   w_in_data;
  logic                   w_r_hs;

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign w_addr[i] = m_araddr[i*A_WIDTH +: A_WIDTH];
    assign w_len[i]  = m_arlen[i*AXI_LEN_W +: AXI_LEN_W];
  end

  rr_picker #(.NM(NM), .IW(IW)) u_picker (
    .i_req     (m_arvalid),
    .i_last    (r_last_grant),
    .o_gnt_oh  (w_req_oh),
    .o_gnt_idx (w_req_idx),
    .o_valid   (w_req_vld)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IW'(NM - 1);
      r_gnt_oh     <= '0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arlen      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req_vld) begin
          r_grant   <= w_req_idx;
          r_gnt_oh  <= w_req_oh;
          r_araddr  <= w_addr[w_req_idx];
          r_arlen   <= w_len[w_req_idx];
          r_arvalid <= 1'b1;
          r_state   <= ADDR;
        end
        ADDR: if (s_arready) begin
          r_arvalid <= 1'b0;
          r_state   <= DATA;
        end
        DATA: if (w_r_hs && s_rlast) begin
          r_last_grant <= r_grant;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // AR request is replayed from the capture registers, so m_arvalid may change after grant
  assign s_arvalid = r_arvalid;
  assign s_araddr  = r_araddr;
  assign s_arlen   = r_arlen;
  assign m_arready = (r_arvalid && s_arready) ? r_gnt_oh : '0;

  assign w_in_data = (r_state == DATA);
  assign s_rready  = w_in_data && m_rready[r_grant];
  assign m_rvalid  = (w_in_data && s_rvalid) ? r_gnt_oh : '0;
  assign m_rdata   = s_rdata;
  assign m_rlast   = s_rlast;
  assign w_r_hs    = s_rvalid && s_rready;

`ifdef AXI_RD_ARB_LEN_CHECK_EN
  logic [AXI_LEN_W-1:0] r_beats;
  logic                 r_len_err;

  // Counter holds beats remaining after the current one; rlast must coincide with zero
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beats   <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (r_arvalid && s_arready) r_beats <= r_arlen;
      if (w_r_hs) begin
        if (s_rlast != (r_beats == '0)) r_len_err <= 1'b1;
        if (r_beats != '0) r_beats <= r_beats - 1'b1;
      end
    end
  end

  assign len_err = r_len_err;
`endif
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Randomized bench for axi4_rd_arbiter: master/slave models plus a transaction-level reference.
module tb_axi4_rd_arbiter;
  localparam int NM = 2;
  localparam int AW = 26;
  localparam int DW = 16;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NM-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM*AW-1:0]  m_araddr;
  logic [NM*8-1:0]   m_arlen;
  logic              m_rlast;
  logic [DW-1:0]     m_rdata;
  logic              s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0]     s_araddr;
  logic [7:0]        s_arlen;
  logic [DW-1:0]     s_rdata;
`ifdef AXI_RD_ARB_LEN_CHECK_EN
  logic              len_err;
`endif

  axi4_rd_arbiter #(.NM(NM), .A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rdata(s_rdata)
`ifdef AXI_RD_ARB_LEN_CHECK_EN
    , .len_err(len_err)
`endif
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // reference state: 0 idle, 1 address phase, 2 data phase
  int phase, g, last_g, e_len, e_beat, cut, ngr, prev_g;
  logic [AW-1:0] e_addr;
  bit has_prev;
  int n_beats [NM];
  int ar_cnt  [NM];
  // master models
  bit pend [NM];
  logic [AW-1:0] ma [NM];
  logic [7:0] ml [NM];
  int mode, dir_m, dir_len, stall_cnt;
  logic [AW-1:0] dir_addr;
  bit dir_go, rr_rand;
  // slave model
  bit sl_busy, sl_rv;
  logic [AW-1:0] sl_addr;
  int sl_len, sl_beat;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
    return a[15:0] ^ 16'(b * 4369) ^ 16'h5a5a;
  endfunction

  function automatic int rr(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++) if (req[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  function automatic bit idle_now();
    bit any = 0;
    for (int i = 0; i < NM; i++) any |= pend[i];
    return phase == 0 && !sl_busy && !any && !dir_go;
  endfunction

  task automatic reset_model();
    phase = 0; g = 0; last_g = NM - 1; cut = -1; has_prev = 0;
    sl_busy = 0; sl_rv = 0; dir_go = 0; stall_cnt = 0;
    for (int i = 0; i < NM; i++) pend[i] = 0;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0;
  endtask

  task automatic observe();
    logic [NM-1:0] oh;
    int exp_last, sl_last;
    oh = (phase != 0) ? (NM'(1) << g) : '0;
    chk("s_arvalid", 32'(s_arvalid), 32'(phase == 1));
    chk("m_arready", 32'(m_arready), (phase == 1 && s_arready) ? 32'(oh) : 32'd0);
    chk("m_rvalid", 32'(m_rvalid), (phase == 2 && s_rvalid) ? 32'(oh) : 32'd0);
    chk("s_rready", 32'(s_rready), 32'(phase == 2 && m_rready[g]));
    if (phase == 1) begin
      chk("s_araddr", 32'(s_araddr), 32'(e_addr));
      chk("s_arlen", 32'(s_arlen), 32'(e_len));
    end
    for (int i = 0; i < NM; i++) if (m_arready[i]) begin pend[i] = 0; ar_cnt[i]++; end
    sl_last = (cut >= 0) ? cut : sl_len;
    if (s_arvalid && s_arready) begin
      sl_busy = 1; sl_addr = s_araddr; sl_len = int'(s_arlen); sl_beat = 0;
    end else if (s_rvalid && s_rready) begin
      sl_rv = 0;
      if (sl_beat == sl_last) sl_busy = 0;
      sl_beat++;
    end
    case (phase)
      0: if (|m_arvalid) begin
        g = rr(m_arvalid, last_g); e_addr = ma[g]; e_len = int'(ml[g]); phase = 1;
        if (mode == 2 && has_prev) chk("no_repeat", 32'(g != prev_g), 32'd1);
        prev_g = g; has_prev = 1;
      end
      1: if (s_arready) begin phase = 2; e_beat = 0; end
      default: if (s_rvalid && m_rready[g]) begin
        exp_last = (cut >= 0) ? cut : e_len;
        chk("rdata", 32'(m_rdata), 32'(beat_data(e_addr, e_beat)));
        chk("rlast", 32'(m_rlast), 32'(e_beat == exp_last));
        n_beats[g]++;
        if (s_rlast) begin phase = 0; last_g = g; ngr++; end
        e_beat++;
      end
    endcase
  endtask

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      if (!pend[i]) begin
        if (mode == 1 && $urandom_range(3) == 0) begin
          pend[i] = 1; ma[i] = AW'($urandom); ml[i] = 8'($urandom_range(7));
        end else if (mode == 2) begin
          pend[i] = 1; ma[i] = AW'($urandom); ml[i] = 8'd0;
        end else if (mode == 3 && i == dir_m && dir_go) begin
          pend[i] = 1; ma[i] = dir_addr; ml[i] = 8'(dir_len); dir_go = 0;
        end
      end
      m_arvalid[i] = pend[i];
      m_araddr[i*AW +: AW] = ma[i];
      m_arlen[i*8 +: 8] = ml[i];
      m_rready[i] = rr_rand ? ($urandom_range(3) != 0) : 1'b1;
    end
    if (stall_cnt > 0) begin m_rready[1] = 1'b0; stall_cnt--; end
    s_arready = 1'($urandom_range(1));
    if (sl_busy && !sl_rv && $urandom_range(3) != 0) begin
      sl_rv = 1; s_rdata = beat_data(sl_addr, sl_beat);
      s_rlast = (sl_beat == ((cut >= 0) ? cut : sl_len));
    end
    s_rvalid = sl_rv;
  endtask

  task automatic step();
    @(negedge aclk); observe();
    @(posedge aclk); #1; drive();
  endtask

  task automatic wait_idle(input int max);
    int t = 0;
    while (!idle_now() && t < max) begin step(); t++; end
    chk("idle_timeout", 32'(idle_now()), 32'd1);
  endtask

  task automatic directed(input int m, input logic [AW-1:0] a, input int len);
    for (int i = 0; i < NM; i++) begin n_beats[i] = 0; ar_cnt[i] = 0; end
    mode = 3; dir_m = m; dir_addr = a; dir_len = len; dir_go = 1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_s_arvalid", 32'(s_arvalid), 0);
    chk("rst_s_araddr", 32'(s_araddr), 0);
    chk("rst_s_arlen", 32'(s_arlen), 0);
    chk("rst_m_arready", 32'(m_arready), 0);
    chk("rst_m_rvalid", 32'(m_rvalid), 0);
    chk("rst_s_rready", 32'(s_rready), 0);
  endtask

  initial begin
    int t;
    mode = 0; rr_rand = 0; ngr = 0;
    reset_model();
    repeat (2) @(posedge aclk);
    #1 chk_reset_outputs();
`ifdef AXI_RD_ARB_LEN_CHECK_EN
    chk("rst_len_err", 32'(len_err), 0);
`endif
    #3 aresetn = 1;
    repeat (100) step();

    // single master, addr 0x100, 4 beats
    directed(0, 26'h0000100, 3);
    wait_idle(200);
    chk("dir_beats_m0", 32'(n_beats[0]), 4);
    chk("dir_beats_m1", 32'(n_beats[1]), 0);
    chk("dir_arready_pulses", 32'(ar_cnt[0]), 1);

    // both masters continuously, single-beat bursts
    mode = 2; has_prev = 0; t = ngr;
    for (int c = 0; c < 400 && ngr < t + 8; c++) step();
    chk("alt_bursts", 32'(ngr >= t + 8), 1);
    mode = 0; wait_idle(200);

    // master 1 stalls its R channel for 5 cycles mid-burst
    directed(1, 26'h2abcde0, 7);
    t = 0;
    while (!(phase == 2 && e_beat >= 2) && t < 300) begin step(); t++; end
    chk("stall_reach", 32'(phase == 2), 1);
    stall_cnt = 5;
    wait_idle(300);
    chk("stall_beats_m1", 32'(n_beats[1]), 8);

    // randomized traffic
    mode = 1; rr_rand = 1;
    repeat (2000) step();
    mode = 0; wait_idle(500);
    rr_rand = 0;

    // maximum burst length
    directed(0, 26'h3fffff0, 255);
    wait_idle(2000);
    chk("len255_beats", 32'(n_beats[0]), 256);

    // asynchronous reset during beat 2 of 8
    directed(1, 26'h0123450, 7);
    t = 0;
    while (!(phase == 2 && e_beat == 2) && t < 300) begin step(); t++; end
    chk("rst_reach", 32'(phase == 2 && e_beat == 2), 1);
    #2 aresetn = 0;
    reset_model();
    #1 chk_reset_outputs();
    @(posedge aclk); #3 aresetn = 1;
    directed(0, 26'h0000200, 2);
    wait_idle(200);
    chk("post_rst_beats", 32'(n_beats[0]), 3);

`ifdef AXI_RD_ARB_LEN_CHECK_EN
    chk("len_err_clean", 32'(len_err), 0);
    directed(0, 26'h0000300, 3);
    cut = 1;
    wait_idle(200);
    cut = -1;
    chk("len_err_set", 32'(len_err), 1);
    directed(1, 26'h0000400, 3);
    wait_idle(200);
    chk("len_err_sticky", 32'(len_err), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
